// File: rtl/fft_pkg.sv
// Shared FFT datapath package: Q-format defaults plus rounding and
// saturation helpers. Helpers work on 64-bit signed values so any
// datapath width up to ~60 bits can reuse them.
package fft_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int TW_WIDTH_DEF   = 16;
   localparam int TW_FRAC        = TW_WIDTH_DEF - 1;

   // Round half up, then arithmetic right shift by sh bits (sh >= 1).
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                      input int sh);
      return (v + (64'sd1 <<< (sh - 1))) >>> sh;
   endfunction

   // Clamp v to the signed range of a w-bit two's complement number.
   function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                       input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         return hi;
      end
      if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/cmul_round.sv
// Two-stage complex multiplier t = W * X with optional conjugate twiddle
// and round-half-up back to the data scale. No saturation here: the
// result keeps two guard bits so callers decide how to clip.
module cmul_round
   import fft_pkg::*;
#(
   parameter int WIDTH    = DATA_WIDTH_DEF,
   parameter int TW_WIDTH = TW_WIDTH_DEF
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_en,
   input  logic                       i_inv,
   input  logic signed [TW_WIDTH-1:0] i_w_re,
   input  logic signed [TW_WIDTH-1:0] i_w_im,
   input  logic signed [WIDTH-1:0]    i_x_re,
   input  logic signed [WIDTH-1:0]    i_x_im,
   output logic signed [WIDTH+1:0]    o_re,
   output logic signed [WIDTH+1:0]    o_im
);

   localparam int FRAC_BITS = TW_WIDTH - 1;
   localparam int EW        = WIDTH + TW_WIDTH + 1;
   localparam int PW        = WIDTH + TW_WIDTH + 2;

   logic signed [WIDTH-1:0]    x_re_q;
   logic signed [WIDTH-1:0]    x_im_q;
   logic signed [TW_WIDTH-1:0] w_re_q;
   logic signed [EW-1:0]       w_im_eff;
   logic signed [EW-1:0]       w_im_q;
   logic signed [PW-1:0]       p_re;
   logic signed [PW-1:0]       p_im;

   // Conjugate twiddle; widened first so negating the most negative value cannot wrap.
   always_comb begin
      w_im_eff = EW'(i_w_im);
      if (i_inv) begin
         w_im_eff = -(EW'(i_w_im));
      end
   end

   // First stage: capture operands and the effective twiddle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x_re_q <= '0;
         x_im_q <= '0;
         w_re_q <= '0;
         w_im_q <= '0;
      end else if (i_en) begin
         x_re_q <= i_x_re;
         x_im_q <= i_x_im;
         w_re_q <= i_w_re;
         w_im_q <= w_im_eff;
      end
   end

   // Full-precision complex products, wide enough that nothing can overflow.
   always_comb begin
      p_re = PW'(w_re_q) * PW'(x_re_q) - PW'(w_im_q) * PW'(x_im_q);
      p_im = PW'(w_re_q) * PW'(x_im_q) + PW'(w_im_q) * PW'(x_re_q);
   end

   // Second stage: drop the twiddle fraction bits with round-half-up.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_re <= '0;
         o_im <= '0;
      end else if (i_en) begin
         o_re <= (WIDTH+2)'(round_shift(64'(p_re), FRAC_BITS));
         o_im <= (WIDTH+2)'(round_shift(64'(p_im), FRAC_BITS));
      end
   end

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: Ya = Xa + W*Xb, Yb = Xa - W*Xb with
// conjugate-twiddle inverse mode, optional halving and output saturation.
// The whole pipeline advances as one unit whenever the output slot is
// free or being drained, so o_ready is a combinational copy of that.
module butterfly_pipe
   import fft_pkg::*;
#(
   parameter int WIDTH    = DATA_WIDTH_DEF,
   parameter int TW_WIDTH = TW_FRAC + 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic                       i_inv,
   input  logic                       i_scale,
   input  logic signed [TW_WIDTH-1:0] i_w_re,
   input  logic signed [TW_WIDTH-1:0] i_w_im,
   input  logic signed [WIDTH-1:0]    i_xa_re,
   input  logic signed [WIDTH-1:0]    i_xa_im,
   input  logic signed [WIDTH-1:0]    i_xb_re,
   input  logic signed [WIDTH-1:0]    i_xb_im,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic signed [WIDTH-1:0]    o_ya_re,
   output logic signed [WIDTH-1:0]    o_ya_im,
   output logic signed [WIDTH-1:0]    o_yb_re,
   output logic signed [WIDTH-1:0]    o_yb_im,
   output logic                       o_sat
);

   logic                    advance;
   logic                    valid_s1;
   logic                    valid_s2;
   logic signed [WIDTH-1:0] xa_re_s1;
   logic signed [WIDTH-1:0] xa_im_s1;
   logic signed [WIDTH-1:0] xa_re_s2;
   logic signed [WIDTH-1:0] xa_im_s2;
   logic                    scale_s1;
   logic                    scale_s2;
   logic signed [WIDTH+1:0] t_re;
   logic signed [WIDTH+1:0] t_im;
   logic signed [63:0]      sum_re;
   logic signed [63:0]      sum_im;
   logic signed [63:0]      dif_re;
   logic signed [63:0]      dif_im;
   logic signed [63:0]      ya_re_sat;
   logic signed [63:0]      ya_im_sat;
   logic signed [63:0]      yb_re_sat;
   logic signed [63:0]      yb_im_sat;
   logic                    sat_any;

   function automatic logic signed [63:0] opt_halve(input logic signed [63:0] v,
                                                    input logic halve);
      return halve ? round_shift(v, 1) : v;
   endfunction

   assign advance = i_ready | ~o_valid;
   assign o_ready = advance;

   cmul_round #(
      .WIDTH   (WIDTH),
      .TW_WIDTH(TW_WIDTH)
   ) u_cmul (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (advance),
      .i_inv  (i_inv),
      .i_w_re (i_w_re),
      .i_w_im (i_w_im),
      .i_x_re (i_xb_re),
      .i_x_im (i_xb_im),
      .o_re   (t_re),
      .o_im   (t_im)
   );

   // Valid bits and the Xa/scale delay line that runs alongside the multiplier.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_s1 <= 1'b0;
         valid_s2 <= 1'b0;
         xa_re_s1 <= '0;
         xa_im_s1 <= '0;
         xa_re_s2 <= '0;
         xa_im_s2 <= '0;
         scale_s1 <= 1'b0;
         scale_s2 <= 1'b0;
      end else if (advance) begin
         valid_s1 <= i_valid;
         valid_s2 <= valid_s1;
         xa_re_s1 <= i_xa_re;
         xa_im_s1 <= i_xa_im;
         xa_re_s2 <= xa_re_s1;
         xa_im_s2 <= xa_im_s1;
         scale_s1 <= i_scale;
         scale_s2 <= scale_s1;
      end
   end

   // Butterfly add/subtract, optional halving, then clip to the data width.
   always_comb begin
      sum_re    = opt_halve(64'(xa_re_s2) + 64'(t_re), scale_s2);
      sum_im    = opt_halve(64'(xa_im_s2) + 64'(t_im), scale_s2);
      dif_re    = opt_halve(64'(xa_re_s2) - 64'(t_re), scale_s2);
      dif_im    = opt_halve(64'(xa_im_s2) - 64'(t_im), scale_s2);
      ya_re_sat = sat_to_width(sum_re, WIDTH);
      ya_im_sat = sat_to_width(sum_im, WIDTH);
      yb_re_sat = sat_to_width(dif_re, WIDTH);
      yb_im_sat = sat_to_width(dif_im, WIDTH);
      sat_any   = (ya_re_sat != sum_re) || (ya_im_sat != sum_im) ||
                  (yb_re_sat != dif_re) || (yb_im_sat != dif_im);
   end

   // Output stage; holds everything while downstream stalls.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_sat   <= 1'b0;
         o_ya_re <= '0;
         o_ya_im <= '0;
         o_yb_re <= '0;
         o_yb_im <= '0;
      end else if (advance) begin
         o_valid <= valid_s2;
         o_sat   <= sat_any;
         o_ya_re <= WIDTH'(ya_re_sat);
         o_ya_im <= WIDTH'(ya_im_sat);
         o_yb_re <= WIDTH'(yb_re_sat);
         o_yb_im <= WIDTH'(yb_im_sat);
      end
   end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed vectors with known
// answers, a stalled stream, a random soak against a behavioural model,
// and an asynchronous reset with work in flight.
module tb_butterfly_pipe;

   localparam int WIDTH    = 16;
   localparam int TW_WIDTH = 16;

   logic                       i_clk   = 1'b0;
   logic                       i_rst_n = 1'b0;
   logic                       i_valid = 1'b0;
   logic                       i_ready = 1'b0;
   logic                       i_inv   = 1'b0;
   logic                       i_scale = 1'b0;
   logic signed [TW_WIDTH-1:0] i_w_re  = '0;
   logic signed [TW_WIDTH-1:0] i_w_im  = '0;
   logic signed [WIDTH-1:0]    i_xa_re = '0;
   logic signed [WIDTH-1:0]    i_xa_im = '0;
   logic signed [WIDTH-1:0]    i_xb_re = '0;
   logic signed [WIDTH-1:0]    i_xb_im = '0;
   logic                       o_ready;
   logic                       o_valid;
   logic                       o_sat;
   logic signed [WIDTH-1:0]    o_ya_re;
   logic signed [WIDTH-1:0]    o_ya_im;
   logic signed [WIDTH-1:0]    o_yb_re;
   logic signed [WIDTH-1:0]    o_yb_im;

   typedef struct {
      int w_re;
      int w_im;
      int xa_re;
      int xa_im;
      int xb_re;
      int xb_im;
      bit inv;
      bit scale;
   } bfly_t;

   typedef struct {
      longint ya_re;
      longint ya_im;
      longint yb_re;
      longint yb_im;
      bit     sat;
      int     issue;
      bit     chk_lat;
   } result_t;

   result_t exp_q[$];
   result_t held;
   bit      hold_pending  = 1'b0;
   int      n_vectors     = 0;
   int      n_miscompares = 0;
   int      cycle         = 0;

   butterfly_pipe #(
      .WIDTH   (WIDTH),
      .TW_WIDTH(TW_WIDTH)
   ) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_inv  (i_inv),
      .i_scale(i_scale),
      .i_w_re (i_w_re),
      .i_w_im (i_w_im),
      .i_xa_re(i_xa_re),
      .i_xa_im(i_xa_im),
      .i_xb_re(i_xb_re),
      .i_xb_im(i_xb_im),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_ya_re(o_ya_re),
      .o_ya_im(o_ya_im),
      .o_yb_re(o_yb_re),
      .o_yb_im(o_yb_im),
      .o_sat  (o_sat)
   );

   // Free-running clock, rising edges at 10, 20, ...
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   // Mathematical floor division, independent of the language's truncating divide.
   function automatic longint floor_div(input longint v, input longint d);
      longint q;
      q = v / d;
      if ((v % d != 0) && ((v < 0) != (d < 0))) begin
         q = q - 1;
      end
      return q;
   endfunction

   function automatic longint finish_out(input longint v, input bit scale, output bit sat);
      longint lim_hi;
      longint lim_lo;
      lim_hi = (longint'(1) << (WIDTH - 1)) - 1;
      lim_lo = -(longint'(1) << (WIDTH - 1));
      sat    = 1'b0;
      if (scale) begin
         v = floor_div(v + 1, 2);
      end
      if (v > lim_hi) begin
         v   = lim_hi;
         sat = 1'b1;
      end else if (v < lim_lo) begin
         v   = lim_lo;
         sat = 1'b1;
      end
      return v;
   endfunction

   // Reference butterfly computed from the arithmetic definition.
   function automatic result_t model(input bfly_t s);
      result_t r;
      longint  wim;
      longint  p_re;
      longint  p_im;
      longint  t_re;
      longint  t_im;
      longint  one_q;
      bit      s0;
      bit      s1;
      bit      s2;
      bit      s3;
      one_q   = longint'(1) << (TW_WIDTH - 1);
      wim     = s.inv ? -longint'(s.w_im) : longint'(s.w_im);
      p_re    = longint'(s.w_re) * s.xb_re - wim * s.xb_im;
      p_im    = longint'(s.w_re) * s.xb_im + wim * s.xb_re;
      t_re    = floor_div(p_re + one_q / 2, one_q);
      t_im    = floor_div(p_im + one_q / 2, one_q);
      r.ya_re = finish_out(s.xa_re + t_re, s.scale, s0);
      r.ya_im = finish_out(s.xa_im + t_im, s.scale, s1);
      r.yb_re = finish_out(s.xa_re - t_re, s.scale, s2);
      r.yb_im = finish_out(s.xa_im - t_im, s.scale, s3);
      r.sat     = s0 | s1 | s2 | s3;
      r.issue   = 0;
      r.chk_lat = 1'b0;
      return r;
   endfunction

   function automatic int rnd_sample();
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) return -32768;
      if (sel == 1) return 32767;
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   function automatic bfly_t rnd_bfly();
      bfly_t s;
      s.w_re  = rnd_sample();
      s.w_im  = rnd_sample();
      s.xa_re = rnd_sample();
      s.xa_im = rnd_sample();
      s.xb_re = rnd_sample();
      s.xb_im = rnd_sample();
      s.inv   = 1'($urandom_range(0, 1));
      s.scale = 1'($urandom_range(0, 1));
      return s;
   endfunction

   // Per-cycle observation: stall stability, ready rule, and scoreboard pop.
   task automatic observe();
      result_t r;
      if (hold_pending) begin
         checkOutput("hold_ya_re", o_ya_re, held.ya_re);
         checkOutput("hold_ya_im", o_ya_im, held.ya_im);
         checkOutput("hold_yb_re", o_yb_re, held.yb_re);
         checkOutput("hold_yb_im", o_yb_im, held.yb_im);
         checkOutput("hold_sat", o_sat, held.sat);
         checkOutput("hold_valid", o_valid, 1);
      end
      checkOutput("o_ready", o_ready, (i_ready || !o_valid));
      hold_pending = o_valid && !i_ready;
      if (hold_pending) begin
         held.ya_re = o_ya_re;
         held.ya_im = o_ya_im;
         held.yb_re = o_yb_re;
         held.yb_im = o_yb_im;
         held.sat   = o_sat;
      end
      if (o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_out", o_valid, 0);
         end else begin
            r = exp_q.pop_front();
            checkOutput("ya_re", o_ya_re, r.ya_re);
            checkOutput("ya_im", o_ya_im, r.ya_im);
            checkOutput("yb_re", o_yb_re, r.yb_re);
            checkOutput("yb_im", o_yb_im, r.yb_im);
            checkOutput("o_sat", o_sat, r.sat);
            if (r.chk_lat) begin
               checkOutput("latency", cycle - r.issue, 3);
            end
         end
      end
   endtask

   // One clock cycle: drive at the falling edge, observe 1 ns later.
   task automatic applyStimulus(input bit valid, input bfly_t s, input bit rdy,
                                input bit directed, input result_t want,
                                output bit accepted);
      result_t r;
      @(negedge i_clk);
      cycle++;
      i_valid = valid;
      i_ready = rdy;
      i_w_re  = 16'(s.w_re);
      i_w_im  = 16'(s.w_im);
      i_xa_re = 16'(s.xa_re);
      i_xa_im = 16'(s.xa_im);
      i_xb_re = 16'(s.xb_re);
      i_xb_im = 16'(s.xb_im);
      i_inv   = s.inv;
      i_scale = s.scale;
      #1;
      observe();
      accepted = valid && o_ready;
      if (accepted) begin
         r         = directed ? want : model(s);
         r.issue   = cycle;
         r.chk_lat = directed;
         exp_q.push_back(r);
      end
   endtask

   task automatic drain();
      bfly_t   idle;
      result_t dummy;
      bit      acc;
      idle  = '{0, 0, 0, 0, 0, 0, 1'b0, 1'b0};
      dummy = '{0, 0, 0, 0, 1'b0, 0, 1'b0};
      for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
         applyStimulus(1'b0, idle, 1'b1, 1'b0, dummy, acc);
      end
      checkOutput("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      bfly_t   dir_in[6];
      result_t dir_out[6];
      bfly_t   s8[8];
      bfly_t   idle;
      result_t dummy;
      bit      acc;
      int      idx;

      idle  = '{0, 0, 0, 0, 0, 0, 1'b0, 1'b0};
      dummy = '{0, 0, 0, 0, 1'b0, 0, 1'b0};

      dir_in[0]  = '{32767, 0, 100, 50, 20, -10, 1'b0, 1'b0};
      dir_out[0] = '{120, 40, 80, 60, 1'b0, 0, 1'b0};
      dir_in[1]  = '{0, 32767, 100, 50, 20, -10, 1'b0, 1'b0};
      dir_out[1] = '{110, 70, 90, 30, 1'b0, 0, 1'b0};
      dir_in[2]  = '{0, 32767, 100, 50, 20, -10, 1'b1, 1'b0};
      dir_out[2] = '{90, 30, 110, 70, 1'b0, 0, 1'b0};
      dir_in[3]  = '{32767, 0, 32000, 0, 32000, 0, 1'b0, 1'b0};
      dir_out[3] = '{32767, 0, 1, 0, 1'b1, 0, 1'b0};
      dir_in[4]  = '{32767, 0, 32000, 0, 32000, 0, 1'b0, 1'b1};
      dir_out[4] = '{32000, 0, 1, 0, 1'b0, 0, 1'b0};
      dir_in[5]  = '{-32768, 0, 0, 0, -32768, 0, 1'b0, 1'b1};
      dir_out[5] = '{16384, 0, -16384, 0, 1'b0, 0, 1'b0};

      // Reset values
      repeat (2) @(negedge i_clk);
      #1;
      checkOutput("rst_valid", o_valid, 0);
      checkOutput("rst_sat", o_sat, 0);
      checkOutput("rst_ya_re", o_ya_re, 0);
      checkOutput("rst_ya_im", o_ya_im, 0);
      checkOutput("rst_yb_re", o_yb_re, 0);
      checkOutput("rst_yb_im", o_yb_im, 0);
      checkOutput("rst_ready", o_ready, 1);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Known-answer vectors, back to back at full throughput
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, dir_in[i], 1'b1, 1'b1, dir_out[i], acc);
      end
      drain();

      // Eight-deep stream with a five-cycle downstream stall in the middle
      for (int i = 0; i < 8; i++) begin
         s8[i] = rnd_bfly();
      end
      idx = 0;
      for (int c = 0; c < 40 && idx < 8; c++) begin
         applyStimulus(1'b1, s8[idx], !(c >= 4 && c < 9), 1'b0, dummy, acc);
         if (acc) begin
            idx++;
         end
      end
      checkOutput("stream_accepted", idx, 8);
      drain();

      // Random soak with random valid/ready gaps
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(0, 3) != 0, rnd_bfly(), $urandom_range(0, 3) != 0,
                       1'b0, dummy, acc);
      end
      drain();

      // Asynchronous reset with two butterflies in flight
      applyStimulus(1'b1, rnd_bfly(), 1'b1, 1'b0, dummy, acc);
      applyStimulus(1'b1, rnd_bfly(), 1'b1, 1'b0, dummy, acc);
      applyStimulus(1'b0, idle, 1'b1, 1'b0, dummy, acc);
      @(negedge i_clk);
      cycle++;
      #1;
      checkOutput("pre_rst_valid", o_valid, 1);
      #1;
      i_rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", o_valid, 0);
      checkOutput("async_rst_sat", o_sat, 0);
      checkOutput("async_rst_ya_re", o_ya_re, 0);
      checkOutput("async_rst_ya_im", o_ya_im, 0);
      checkOutput("async_rst_yb_re", o_yb_re, 0);
      checkOutput("async_rst_yb_im", o_yb_im, 0);
      exp_q.delete();
      hold_pending = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b0, idle, 1'b1, 1'b0, dummy, acc);
      end
      checkOutput("post_rst_valid", o_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Parametrised, fully pipelined radix-2 DIT butterfly for the FFT datapath.
- Computes t = W·Xb, then Ya = Xa + t and Yb = Xa − t, in signed fixed point.
- Adds per-sample inverse (conjugate-twiddle) mode, optional divide-by-2 scaling, convergent-free round-half-up, saturation, and valid/ready flow control.
- Sits between the stage address generator/memory read port and the memory write-back port; one butterfly accepted per clock when not stalled.

Parameters:
- WIDTH, 16, data width of each real/imag sample, two's complement.
- TW_WIDTH, 16, twiddle width; format Q1.(TW_WIDTH-1), i.e. value = w / 2^(TW_WIDTH-1).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input butterfly present.
- o_ready  out  1  block can accept input this cycle.
- i_inv  in  1  1 = use conj(W) (inverse FFT); sampled with data.
- i_scale  in  1  1 = halve both outputs (with rounding); sampled with data.
- i_w_re, i_w_im  in  TW_WIDTH  twiddle, signed.
- i_xa_re, i_xa_im, i_xb_re, i_xb_im  in  WIDTH  inputs, signed.
- o_valid  out  1  output butterfly present.
- i_ready  in  1  downstream accepts output.
- o_ya_re, o_ya_im, o_yb_re, o_yb_im  out  WIDTH  results, signed.
- o_sat  out  1  at least one of the four outputs of this result was saturated; qualified by o_valid.

Behaviour:
- Reset (async assert, sync release): all pipeline valids, o_valid, o_sat, and all data outputs = 0. Reset mid-operation discards every in-flight butterfly; none reappears after release.
- Pipeline: 3 register stages. Latency is exactly 3 cycles from input handshake (i_valid & o_ready) to o_valid, with no stall.
  - S1: register xa, xb, w, mode bits; if inv, w_im_eff = −w_im, computed at WIDTH+TW_WIDTH+1 bits so −(−2^(TW_WIDTH-1)) does not overflow.
  - S2: full-precision products. p_re = w_re·xb_re − w_im_eff·xb_im; p_im = w_re·xb_im + w_im_eff·xb_re, both at WIDTH+TW_WIDTH+2 bits. Round: t = (p + 2^(TW_WIDTH-2)) >>> (TW_WIDTH-1), arithmetic shift. Keep t at WIDTH+2 bits; no saturation at this point.
  - S3: sum = xa + t, diff = xa − t at WIDTH+3 bits. If scale: v = (v + 1) >>> 1. Then saturate each to [−2^(WIDTH-1), 2^(WIDTH-1)−1]. o_sat = OR of the four saturation events.
- Flow control:
  - advance = i_ready | ~o_valid. All stages shift together when advance = 1; they hold when advance = 0.
  - o_ready = advance, which is combinational from i_ready; this path is accepted.
  - Bubbles (valid = 0) propagate. While stalled, outputs and o_sat stay stable.
  - No sample is dropped or duplicated; order is preserved.
- Simultaneous input handshake and output handshake in the same cycle is the normal full-throughput case.
- Stage valids only qualify data. Data registers may load garbage when their valid is 0, but must be 0 after reset.

Decomposition:
- Shared package fft_pkg:
  - round/saturate helper functions (sat_to_width, round_shift).
  - the Q-format constant TW_FRAC = TW_WIDTH−1.
- One natural sub-module: cmul_round, the complex multiply with conj option and rounding (S1–S2). Instantiated once; reused later by the twiddle-rotation block.

Test Plan (WIDTH = TW_WIDTH = 16):
- W = (32767, 0), Xa = (100, 50), Xb = (20, −10), inv = 0, scale = 0 -> 3 cycles later Ya = (120, 40), Yb = (80, 60), o_sat = 0.
- W = (0, 32767), same X, inv = 0 -> Ya = (110, 70), Yb = (90, 30); with inv = 1 -> Ya = (90, 30), Yb = (110, 70).
- W = (32767, 0), Xa = (32000, 0), Xb = (32000, 0):
  - scale = 0 -> Ya_re = 32767, Yb_re = 1, o_sat = 1.
  - scale = 1 -> Ya_re = 32000, Yb_re = 1, o_sat = 0.
- W = (−32768, 0), Xb = (−32768, 0), Xa = 0, scale = 1 -> t_re = 32768 internally, Ya_re = 16384, Yb_re = −16384, no overflow.
- Stream 8 butterflies back-to-back, then hold i_ready = 0 for 5 cycles mid-stream:
  - o_ready drops while o_valid = 1.
  - Outputs are held stable.
  - All 8 results arrive in order, none lost.
- Reset pulse with 2 butterflies in flight -> o_valid = 0 and outputs = 0 immediately (asynchronously); no stale output after release.
